rhs_headstage_slave_emu: RTL and testbench

//  Parametrised behavioural emulator of an RHS headstage SPI slave for bench and loopback use.

---
 rtl/rhs_slave_pkg.sv | 56 +++++
 rtl/rhs_slave_delay_line.sv | 29 ++
 rtl/rhs_headstage_slave_emu.sv | 196 +++++++++++++++++++
 tb/tb_rhs_headstage_slave_emu.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/rhs_slave_pkg.sv
// Shared types, frame constants, ROM contents and response-word builders for the
// RHS headstage SPI slave emulator.
package rhs_slave_pkg;

    localparam int unsigned FRAME_BITS = 32;

    typedef enum logic [1:0] {
        OpConvert = 2'b00,
        OpClear   = 2'b01,
        OpWrite   = 2'b10,
        OpRead    = 2'b11
    } opcode_e;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDecode
    } state_e;

    localparam logic [7:0]  ROM_BASE     = 8'd251;
    localparam logic [15:0] ROM_INTAN_I  = 16'h4900;
    localparam logic [15:0] ROM_INTAN_TA = 16'h5441;
    localparam logic [15:0] ROM_INTAN_N  = 16'h4E00;
    localparam logic [15:0] ROM_DIE_REV  = 16'h0001;
    localparam logic [15:0] ROM_CHIP_ID  = 16'h0020;

    function automatic logic is_rom(input logic [7:0] addr);
        return addr >= ROM_BASE;
    endfunction

    function automatic logic [15:0] rom_value(input logic [7:0] addr);
        logic [15:0] val;
        case (addr)
            8'd251:  val = ROM_INTAN_I;
            8'd252:  val = ROM_INTAN_TA;
            8'd253:  val = ROM_INTAN_N;
            8'd254:  val = ROM_DIE_REV;
            8'd255:  val = ROM_CHIP_ID;
            default: val = 16'h0000;
        endcase
        return val;
    endfunction

    function automatic logic [31:0] convert_resp(input logic [15:0] sample);
        return {sample, 16'h0000};
    endfunction

    function automatic logic [31:0] write_resp(input logic [15:0] data);
        return {16'hFFFF, data};
    endfunction

    function automatic logic [31:0] read_resp(input logic [15:0] data);
        return {16'h0000, data};
    endfunction

endpackage

// File: rtl/rhs_slave_delay_line.sv
// MISO delay line emulating cable round-trip; DEPTH flops, wire when DEPTH is 0.
module rhs_slave_delay_line #(
    parameter int unsigned DEPTH = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    if (DEPTH == 0) begin : g_bypass
        logic unused_clk_rst;
        assign unused_clk_rst = clk ^ rst;
        assign dout = din;
    end else begin : g_delay
        logic [DEPTH-1:0] sr_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                sr_q <= '0;
            end else begin
                sr_q <= (sr_q << 1) | DEPTH'(din);
            end
        end

        assign dout = sr_q[DEPTH-1];
    end

endmodule

// File: rtl/rhs_headstage_slave_emu.sv
// Behavioural RHS headstage SPI slave: oversampled frame decode, register file, two-frame
// response pipeline. Define RHS_SLAVE_RAMP_EN to give each convert channel a ramp counter.
module rhs_headstage_slave_emu
    import rhs_slave_pkg::*;
#(
    parameter int unsigned NUM_CHANNELS    = 16,
    parameter int unsigned NUM_REGS        = 256,
    parameter logic [15:0] STARTING_SEED   = 16'h0000,
    parameter int unsigned MISO_DELAY_CLKS = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        CS,
    input  logic        SCLK,
    input  logic        MOSI,
    output logic        MISO,
    output logic        frame_done,
    output logic        frame_err,
    output logic [31:0] last_cmd
);

    // Synchronisers are left out of reset so a CS held low across reset is not seen as a fall.
    logic [1:0] cs_sync, sclk_sync, mosi_sync;
    logic       cs_prev, sclk_prev;
    logic       cs_s, mosi_s;
    logic       cs_fall, cs_rise, sclk_rise, sclk_fall;

    always_ff @(posedge clk) begin
        cs_sync   <= {cs_sync[0], CS};
        sclk_sync <= {sclk_sync[0], SCLK};
        mosi_sync <= {mosi_sync[0], MOSI};
        cs_prev   <= cs_sync[1];
        sclk_prev <= sclk_sync[1];
    end

    assign cs_s      = cs_sync[1];
    assign mosi_s    = mosi_sync[1];
    assign cs_fall   = cs_prev & ~cs_s;
    assign cs_rise   = ~cs_prev & cs_s;
    assign sclk_rise = ~sclk_prev & sclk_sync[1];
    assign sclk_fall = sclk_prev & ~sclk_sync[1];

    state_e      state_q, state_d;
    logic [5:0]  bit_cnt_q;
    logic [31:0] rx_sr_q, tx_sr_q;
    logic        miso_q;
    logic [31:0] resp_q0, resp_q1, last_cmd_q;
    logic        frame_done_q, frame_err_q;
    logic [15:0] regs_q [256];

    logic        frame_end, frame_good;

    assign frame_end  = (state_q == StShift) && cs_rise;
    assign frame_good = frame_end && (bit_cnt_q == 6'(FRAME_BITS));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (cs_fall) state_d = StShift;
            StShift:  if (cs_rise) state_d = frame_good ? StDecode : StIdle;
            StDecode: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt_q <= '0;
            rx_sr_q   <= '0;
            tx_sr_q   <= '0;
            miso_q    <= 1'b0;
        end else if ((state_q == StIdle) && cs_fall) begin
            bit_cnt_q <= '0;
            rx_sr_q   <= '0;
            tx_sr_q   <= resp_q1;
            miso_q    <= resp_q1[31];
        end else if ((state_q == StShift) && !cs_s) begin
            if (sclk_rise) begin
                rx_sr_q <= {rx_sr_q[30:0], mosi_s};
                if (bit_cnt_q != 6'h3F) begin
                    bit_cnt_q <= bit_cnt_q + 6'd1;
                end
            end
            if (sclk_fall) begin
                tx_sr_q <= {tx_sr_q[30:0], 1'b0};
                miso_q  <= tx_sr_q[30];
            end
        end
    end

    // Decode works on the captured word while in StDecode.
    opcode_e     cmd_op;
    logic [5:0]  cmd_ch;
    logic [7:0]  cmd_addr;
    logic [15:0] cmd_data;
    logic        ch_valid, addr_valid;
    logic [15:0] ramp_val, sample, reg_rd;
    logic [31:0] resp_new;
    logic        reg_we;

    assign cmd_op     = opcode_e'(rx_sr_q[31:30]);
    assign cmd_ch     = rx_sr_q[21:16];
    assign cmd_addr   = rx_sr_q[23:16];
    assign cmd_data   = rx_sr_q[15:0];
    assign ch_valid   = 32'(cmd_ch) < NUM_CHANNELS;
    assign addr_valid = 32'(cmd_addr) < NUM_REGS;

`ifdef RHS_SLAVE_RAMP_EN
    logic [15:0] cnt_q [64];
    logic        ramp_inc;

    assign ramp_inc = (state_q == StDecode) && (cmd_op == OpConvert) && ch_valid;
    assign ramp_val = cnt_q[cmd_ch];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < 64; c++) begin
                cnt_q[c] <= '0;
            end
        end else if (ramp_inc) begin
            cnt_q[cmd_ch] <= cnt_q[cmd_ch] + 16'd1;
        end
    end
`else
    assign ramp_val = 16'h0000;
`endif

    assign sample = {10'd0, cmd_ch} + STARTING_SEED + ramp_val;

    always_comb begin
        reg_rd = 16'h0000;
        if (addr_valid) begin
            reg_rd = is_rom(cmd_addr) ? rom_value(cmd_addr) : regs_q[cmd_addr];
        end
    end

    always_comb begin
        resp_new = 32'h0000_0000;
        unique case (cmd_op)
            OpConvert: resp_new = ch_valid ? convert_resp(sample) : 32'h0000_0000;
            OpClear:   resp_new = 32'h0000_0000;
            OpWrite:   resp_new = write_resp(cmd_data);
            OpRead:    resp_new = read_resp(reg_rd);
            default:   resp_new = 32'h0000_0000;
        endcase
    end

    assign reg_we = (state_q == StDecode) && (cmd_op == OpWrite) && addr_valid
                    && !is_rom(cmd_addr);

    always_ff @(posedge clk) begin
        if (rst) begin
            resp_q0      <= '0;
            resp_q1      <= '0;
            last_cmd_q   <= '0;
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
            for (int r = 0; r < 256; r++) begin
                regs_q[r] <= '0;
            end
        end else begin
            frame_done_q <= (state_q == StDecode);
            frame_err_q  <= frame_end && !frame_good;
            if (state_q == StDecode) begin
                resp_q1    <= resp_q0;
                resp_q0    <= resp_new;
                last_cmd_q <= rx_sr_q;
            end
            if (reg_we) begin
                regs_q[cmd_addr] <= cmd_data;
            end
        end
    end

    rhs_slave_delay_line #(
        .DEPTH(MISO_DELAY_CLKS)
    ) u_miso_delay (
        .clk (clk),
        .rst (rst),
        .din (miso_q),
        .dout(MISO)
    );

    assign frame_done = frame_done_q;
    assign frame_err  = frame_err_q;
    assign last_cmd   = last_cmd_q;

endmodule

// File: tb/tb_rhs_headstage_slave_emu.sv
// Bench for rhs_headstage_slave_emu: table-driven frames with a response scoreboard,
// plus error-frame, mid-frame reset and MISO delay latency sequences.
module tb_rhs_headstage_slave_emu;

    localparam int HALF = 5;  // clk cycles per SCLK half period

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic CS = 1'b1;
    logic SCLK = 1'b0;
    logic MOSI = 1'b0;

    logic        miso_m, done_m, err_m;
    logic [31:0] last_m;
    logic        miso_d, unused_done_d, unused_err_d;
    logic [31:0] last_d;
    logic        miso_s, unused_done_s, unused_err_s;
    logic [31:0] last_s;

    always #5 clk = ~clk;

    rhs_headstage_slave_emu dut (
        .clk(clk), .rst(rst), .CS(CS), .SCLK(SCLK), .MOSI(MOSI),
        .MISO(miso_m), .frame_done(done_m), .frame_err(err_m), .last_cmd(last_m)
    );

    rhs_headstage_slave_emu #(.MISO_DELAY_CLKS(5)) dut_dly (
        .clk(clk), .rst(rst), .CS(CS), .SCLK(SCLK), .MOSI(MOSI),
        .MISO(miso_d), .frame_done(unused_done_d), .frame_err(unused_err_d), .last_cmd(last_d)
    );

    rhs_headstage_slave_emu #(.STARTING_SEED(16'hFFFC)) dut_seed (
        .clk(clk), .rst(rst), .CS(CS), .SCLK(SCLK), .MOSI(MOSI),
        .MISO(miso_s), .frame_done(unused_done_s), .frame_err(unused_err_s), .last_cmd(last_s)
    );

    typedef struct {
        string       name;
        logic [31:0] cmd;
        logic [31:0] exp_m;
        logic [31:0] exp_s;
    } vec_t;

    vec_t        tbl[$];
    logic [31:0] q_m[$];
    logic [31:0] q_s[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          done_cnt = 0;
    int          err_cnt = 0;
    int          cyc, lat_m, lat_d;
    logic [31:0] last_good;

    always @(negedge clk) begin
        if (done_m) done_cnt <= done_cnt + 1;
        if (err_m)  err_cnt  <= err_cnt + 1;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h, expected %08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        cyc++;
        if (miso_m === 1'b1 && lat_m < 0) lat_m = cyc;
        if (miso_d === 1'b1 && lat_d < 0) lat_d = cyc;
    endtask

    task automatic run_frame(input logic [31:0] cmd, input int nbits,
                             output logic [31:0] rx_m, output logic [31:0] rx_s);
        logic [63:0] sr;
        sr    = {cmd, 32'h0};
        cyc   = 0;
        lat_m = -1;
        lat_d = -1;
        rx_m  = '0;
        rx_s  = '0;
        CS    = 1'b0;
        SCLK  = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            MOSI = sr[63];
            sr   = {sr[62:0], 1'b0};
            repeat (HALF) tick();
            rx_m = {rx_m[30:0], miso_m};
            rx_s = {rx_s[30:0], miso_s};
            SCLK = 1'b1;
            repeat (HALF) tick();
            SCLK = 1'b0;
        end
        MOSI = 1'b0;
        repeat (HALF) tick();
        CS = 1'b1;
        repeat (8) tick();
    endtask

    task automatic apply(input string name, input logic [31:0] cmd,
                         input logic [31:0] exp_m, input logic [31:0] exp_s);
        int          d0, e0;
        logic [31:0] rm, rs, pm, ps;
        d0 = done_cnt;
        e0 = err_cnt;
        q_m.push_back(exp_m);
        q_s.push_back(exp_s);
        run_frame(cmd, 32, rm, rs);
        pm = q_m.pop_front();
        ps = q_s.pop_front();
        check({name, " miso"}, rm, pm);
        check({name, " seed miso"}, rs, ps);
        check({name, " last_cmd"}, last_m, cmd);
        check({name, " seed last_cmd"}, last_s, cmd);
        check({name, " done pulses"}, 32'(done_cnt - d0), 32'd1);
        check({name, " err pulses"}, 32'(err_cnt - e0), 32'd0);
        if (pm[31]) begin
            check({name, " msb latency"}, 32'(lat_m), 32'd3);
            check({name, " delayed msb latency"}, 32'(lat_d), 32'd8);
        end
        last_good = cmd;
    endtask

    task automatic bad_frame(input string name, input int nbits);
        int          d0, e0;
        logic [31:0] rm, rs;
        d0 = done_cnt;
        e0 = err_cnt;
        run_frame(32'h8010_5555, nbits, rm, rs);
        check({name, " err pulses"}, 32'(err_cnt - e0), 32'd1);
        check({name, " done pulses"}, 32'(done_cnt - d0), 32'd0);
        check({name, " last_cmd kept"}, last_m, last_good);
    endtask

    initial begin
        logic [31:0] d0, e0;

        tbl.push_back('{"conv3",   32'h0003_0000, 32'h0003_0000, 32'hFFFF_0000});
        tbl.push_back('{"conv4",   32'h0004_0000, 32'h0004_0000, 32'h0000_0000});
        tbl.push_back('{"conv5",   32'h0005_0000, 32'h0005_0000, 32'h0001_0000});
        tbl.push_back('{"wr10",    32'h8010_BEEF, 32'hFFFF_BEEF, 32'hFFFF_BEEF});
        tbl.push_back('{"rd10",    32'hC010_0000, 32'h0000_BEEF, 32'h0000_BEEF});
        tbl.push_back('{"rd251",   32'hC0FB_0000, 32'h0000_4900, 32'h0000_4900});
        tbl.push_back('{"rd252",   32'hC0FC_0000, 32'h0000_5441, 32'h0000_5441});
        tbl.push_back('{"rd253",   32'hC0FD_0000, 32'h0000_4E00, 32'h0000_4E00});
        tbl.push_back('{"wr252",   32'h80FC_1234, 32'hFFFF_1234, 32'hFFFF_1234});
        tbl.push_back('{"rd252b",  32'hC0FC_0000, 32'h0000_5441, 32'h0000_5441});
        tbl.push_back('{"rd254",   32'hC0FE_0000, 32'h0000_0001, 32'h0000_0001});
        tbl.push_back('{"rd255",   32'hC0FF_0000, 32'h0000_0020, 32'h0000_0020});
        tbl.push_back('{"clear",   32'h4000_0000, 32'h0000_0000, 32'h0000_0000});
        tbl.push_back('{"conv16",  32'h0010_0000, 32'h0000_0000, 32'h0000_0000});
        tbl.push_back('{"conv63",  32'h003F_0000, 32'h0000_0000, 32'h0000_0000});
        tbl.push_back('{"rd11",    32'hC011_0000, 32'h0000_0000, 32'h0000_0000});
        tbl.push_back('{"wr00",    32'h8000_0001, 32'hFFFF_0001, 32'hFFFF_0001});
        tbl.push_back('{"rd00",    32'hC000_0000, 32'h0000_0001, 32'h0000_0001});

        repeat (6) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("reset miso", {31'd0, miso_m}, 32'd0);
        check("reset delayed miso", {31'd0, miso_d}, 32'd0);
        check("reset frame_done", {31'd0, done_m}, 32'd0);
        check("reset frame_err", {31'd0, err_m}, 32'd0);
        check("reset last_cmd", last_m, 32'd0);

        q_m = '{32'd0, 32'd0};
        q_s = '{32'd0, 32'd0};
        last_good = '0;

        foreach (tbl[i]) begin
            apply(tbl[i].name, tbl[i].cmd, tbl[i].exp_m, tbl[i].exp_s);
        end

`ifdef RHS_SLAVE_RAMP_EN
        apply("ramp0", 32'h0002_0000, 32'h0002_0000, 32'hFFFE_0000);
        apply("ramp1", 32'h0002_0000, 32'h0003_0000, 32'hFFFF_0000);
        apply("ramp2", 32'h0002_0000, 32'h0004_0000, 32'h0000_0000);
`else
        apply("const0", 32'h0002_0000, 32'h0002_0000, 32'hFFFE_0000);
        apply("const1", 32'h0002_0000, 32'h0002_0000, 32'hFFFE_0000);
`endif

        bad_frame("short20", 20);
        bad_frame("long40", 40);

        apply("flush0", 32'h4000_0000, 32'h0000_0000, 32'h0000_0000);
        apply("flush1", 32'h4000_0000, 32'h0000_0000, 32'h0000_0000);
        apply("flush2", 32'h4000_0000, 32'h0000_0000, 32'h0000_0000);

        // Reset in the middle of a frame, release, then raise CS: nothing should be reported.
        d0 = 32'(done_cnt);
        e0 = 32'(err_cnt);
        CS   = 1'b0;
        SCLK = 1'b0;
        for (int i = 0; i < 10; i++) begin
            MOSI = i[0];
            repeat (HALF) tick();
            SCLK = 1'b1;
            repeat (HALF) tick();
            SCLK = 1'b0;
        end
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        repeat (3) tick();
        CS = 1'b1;
        repeat (8) tick();
        check("midrst done pulses", 32'(done_cnt) - d0, 32'd0);
        check("midrst err pulses", 32'(err_cnt) - e0, 32'd0);
        check("midrst last_cmd", last_m, 32'd0);
        check("midrst miso", {31'd0, miso_m}, 32'd0);

        q_m.delete();
        q_s.delete();
        q_m = '{32'd0, 32'd0};
        q_s = '{32'd0, 32'd0};
        apply("post rd10", 32'hC010_0000, 32'h0000_0000, 32'h0000_0000);
        apply("post wr10", 32'h8010_00AA, 32'hFFFF_00AA, 32'hFFFF_00AA);
        apply("post clr0", 32'h4000_0000, 32'h0000_0000, 32'h0000_0000);
        apply("post clr1", 32'h4000_0000, 32'h0000_0000, 32'h0000_0000);
        check("delayed last_cmd", last_d, 32'h4000_0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
